// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the interval pulse scheduler: channel state encoding,
// default counter widths and the channel-select width helper.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ON   = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 28;
  localparam int REP_W_DEF = 8;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One scheduler channel: timing registers, WAIT/ON down counter, pulse
// counter and the IDLE/WAIT/ON sequencer with registered outputs.
module pulse_channel
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] interval_i,
  input  logic [CNT_W-1:0] on_time_i,
  input  logic [REP_W-1:0] reps_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             pulse_o,
  output logic             active_o,
  output logic             done_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REP_W-1:0]   left_q, left_d;
  logic [CNT_W-1:0]   interval_q, interval_d;
  logic [CNT_W-1:0]   on_time_q, on_time_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic               pulse_q, pulse_d;
  logic               active_q, active_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   interval_eff, on_time_eff;
  logic [REP_W-1:0]   reps_eff;
  logic [CNT_W-1:0]   wait_len, on_len;
  logic               finite;

  // A load in the same cycle as a start or reload is seen by that start/reload.
  assign interval_eff = load_i ? interval_i : interval_q;
  assign on_time_eff  = load_i ? on_time_i  : on_time_q;
  assign reps_eff     = load_i ? reps_i     : reps_q;

  // Counter preload is max(x,1)-1, so a programmed 0 behaves like 1.
  assign wait_len = (interval_eff == '0) ? '0 : interval_eff - CNT_W'(1);
  assign on_len   = (on_time_eff  == '0) ? '0 : on_time_eff  - CNT_W'(1);
  assign finite   = (reps_eff != '0);

  always_comb begin
    // NOTE: every always_comb output is given a default first so no path
    // through the case statement can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    interval_d = interval_eff;
    on_time_d  = on_time_eff;
    reps_d     = reps_eff;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_WAIT;
          cnt_d   = wait_len;
          left_d  = reps_eff;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
          cnt_d   = on_len;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ON: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (finite && left_q == REP_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          if (finite) left_d = left_q - REP_W'(1);
          state_d = ST_WAIT;
          cnt_d   = wait_len;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a coincident start or completion.
    if (stop_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    pulse_d  = (state_d == ST_ON);
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      left_q     <= '0;
      interval_q <= '0;
      on_time_q  <= '0;
      reps_q     <= '0;
      pulse_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      interval_q <= interval_d;
      on_time_q  <= on_time_d;
      reps_q     <= reps_d;
      pulse_q    <= pulse_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign pulse_o  = pulse_q;
  assign active_o = active_q;
  assign done_o   = done_q;

endmodule

// File: rtl/interval_pulse_sched.sv
// Multi-channel programmable pulse scheduler: decodes the shared load port
// and instantiates one independent pulse_channel per output.
module interval_pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int REP_W    = REP_W_DEF
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         load,
  input  logic [sel_w(CHANNELS)-1:0]   load_ch,
  input  logic [CNT_W-1:0]             load_interval,
  input  logic [CNT_W-1:0]             load_on_time,
  input  logic [REP_W-1:0]             load_reps,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS-1:0]          stop,
  output logic [CHANNELS-1:0]          pulse,
  output logic [CHANNELS-1:0]          active,
  output logic [CHANNELS-1:0]          done
);

  localparam int SEL_W = sel_w(CHANNELS);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // An out-of-range load_ch matches no instance and is dropped.
    logic load_hit;
    assign load_hit = load && (load_ch == SEL_W'(c));

    pulse_channel #(
      .CNT_W (CNT_W),
      .REP_W (REP_W)
    ) u_ch (
      .clk_i      (CLOCK_50),
      .rst_i      (reset),
      .load_i     (load_hit),
      .interval_i (load_interval),
      .on_time_i  (load_on_time),
      .reps_i     (load_reps),
      .start_i    (start[c]),
      .stop_i     (stop[c]),
      .pulse_o    (pulse[c]),
      .active_o   (active[c]),
      .done_o     (done[c])
    );
  end

endmodule

// File: doc/interval_pulse_sched.md
# interval_pulse_sched

Multi-channel programmable pulse scheduler for the actuator outputs (motor drive, indicator strobes) on the GPIO header. Each channel waits a programmable interval, then drives its output high for a programmable on-time. It repeats either a fixed number of times or indefinitely. It replaces the single fixed-interval, fixed-on-time countdown with per-channel runtime-loadable timing, finite or endless pulse trains, abort, and completion reporting.

## Interface
- CHANNELS, 2: number of independent pulse channels (1..8).
- CNT_W, 28: width of interval and on-time counters, in clock cycles.
- REP_W, 8: width of the repetition count.

- CLOCK_50  in  1: system clock; all logic on its rising edge.
- reset  in  1: synchronous, active-high; clears every channel.
- load  in  1: write strobe for one channel's timing registers.
- load_ch  in  $clog2(CHANNELS) (min 1): channel addressed by load.
- load_interval  in  CNT_W: WAIT length in cycles; 0 is treated as 1.
- load_on_time  in  CNT_W: ON length in cycles; 0 is treated as 1.
- load_reps  in  REP_W: number of pulses; 0 means endless.
- start  in  CHANNELS: per-channel start; honoured only in IDLE.
- stop  in  CHANNELS: per-channel abort; honoured in any state.
- pulse  out  CHANNELS: registered pulse outputs.
- active  out  CHANNELS: channel state is not IDLE.
- done  out  CHANNELS: one-cycle flag when a finite train completes.

## Operation
- Per-channel timing registers are interval, on_time and reps. All reset to 0. load with load_ch out of range is ignored.
- Each channel also has a down counter cnt (CNT_W) and a pulse counter left (REP_W).
- IDLE:
  - On start, load cnt with max(interval,1)-1 and left with reps, then go to WAIT.
- WAIT:
  - If cnt is 0, go to ON and load cnt with max(on_time,1)-1.
  - Otherwise decrement cnt.
- ON:
  - pulse is 1. If cnt is 0, the pulse ends.
  - If reps≠0 and left==1, go to IDLE and assert done for one cycle.
  - Otherwise decrement left (only if reps≠0), reload cnt from interval and go to WAIT.
- stop in any state: go to IDLE, pulse=0, no done.
- stop and start asserted together: stop wins.
- start outside IDLE is ignored.
- load to a running channel updates the registers immediately. The new values take effect at the next reload of cnt. left is unaffected.
- load and start to the same channel in the same cycle: the start uses the newly loaded values.
- Channels are fully independent. Simultaneous starts on several channels are all honoured.

## Timing
- Reset values: pulse=0, active=0, done=0, all states IDLE, all registers 0.
- A reset asserted mid-train takes effect at the next edge. pulse falls that edge and no done is produced.
- Let I=max(interval,1), T=max(on_time,1), and let start be sampled at edge E0:
  - active is high from E0+1.
  - pulse is high for cycles E0+I+1 .. E0+I+T.
  - The period is I+T. The k-th pulse rises at E0+k(I+T)-T+1.
- For a finite train of N pulses:
  - pulse falls and done is high for exactly one cycle starting at E0+N(I+T)+1.
  - active falls on that same edge.
- A stop sampled at edge Es clears pulse and active from Es+1.
- An endless train (reps=0) never asserts done.
- No combinational path from any input to any output.

## Structure
- The shared package pulse_sched_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, ON=2'd2);
  - CNT_W and REP_W defaults;
  - the helper for select width (clog2, minimum 1).
- Sub-module pulse_channel holds one channel's registers, counters and FSM.
- The top level decodes load_ch and generates CHANNELS instances.

## Test plan
- Reset, then load ch0 with interval=4, on_time=2, reps=3, then start[0] at E0:
  - pulse[0] is high during cycles 5-6, 11-12 and 17-18.
  - done[0] is high at cycle 19 only, and active[0] is low from cycle 19.
- Load ch1 with interval=0, on_time=0, reps=0, then start:
  - pulse[1] alternates 0,1 with period 2 indefinitely.
  - done[1] never asserts.
- While ch0 is in ON with interval=10, on_time=5, reps=0, assert stop[0]:
  - pulse[0] and active[0] are 0 the next cycle; done is not asserted.
- Assert start[0] and stop[0] together while ch0 is IDLE:
  - the channel stays IDLE and pulse[0] stays 0.
- While ch0 is mid-WAIT (interval=8, on_time=2), load on_time=6:
  - the current ON phase lasts 6 cycles;
  - the subsequent WAIT lasts 8 cycles.
- Assert reset during ch1's third pulse of a 5-pulse train:
  - all outputs are 0 the next cycle;
  - a subsequent start with the registers reloaded produces a fresh full train.
